bsg_print_stat_event_queue: RTL and testbench

Downstream consumer of the print-stat snoop outputs. Timestamps each snooped print-stat event with a free-running cycle counter and buffers {tag, timestamp} pairs in a FIFO. The host-side profiler drains the FIFO through a valid/yumi interface. Events arriving while the FIFO is full are dropped and counted, never stalling the manycore.

---
 rtl/bsg_print_stat_event_queue.sv | 99 +++++++++
 tb/tb_bsg_print_stat_event_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_print_stat_event_queue.sv
// bsg_print_stat_event_queue
//   Timestamps snooped print-stat events with a free-running cycle counter and
//   buffers {tag, timestamp} pairs in a FIFO drained through valid/yumi.
//   Events that find the FIFO full are dropped and counted; the producer is
//   never stalled.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   print_stat_v_i/tag_i  one-cycle event pulse and its tag
//   v_o, tag_o,
//   timestamp_o           head entry (tag/timestamp don't-care while v_o=0)
//   yumi_i                pop head this cycle (only legal when v_o=1)
//   count_o               registered occupancy, 0..els_p
//   drop_count_o          saturating count of dropped events
//   clear_drop_i          zero the drop counter at the next edge (wins over a drop)
//   cycle_o               current cycle counter value
module bsg_print_stat_event_queue #(
  parameter int data_width_p      = 32,
  parameter int els_p             = 16,
  parameter int timestamp_width_p = 48,
  parameter int drop_width_p      = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           print_stat_v_i,
  input  logic [data_width_p-1:0]        print_stat_tag_i,
  output logic                           v_o,
  output logic [data_width_p-1:0]        tag_o,
  output logic [timestamp_width_p-1:0]   timestamp_o,
  input  logic                           yumi_i,
  output logic [$clog2(els_p+1)-1:0]     count_o,
  output logic [drop_width_p-1:0]        drop_count_o,
  input  logic                           clear_drop_i,
  output logic [timestamp_width_p-1:0]   cycle_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [data_width_p-1:0]      tag_mem [els_p];
  logic [timestamp_width_p-1:0] ts_mem  [els_p];

  logic [ptr_w_lp-1:0]          rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp-1:0]          count_r;
  logic [timestamp_width_p-1:0] cycle_r;
  logic [drop_width_p-1:0]      drop_r;

  logic full, deq, enq, drop;

  // A pop with nothing queued is ignored so an illegal yumi cannot corrupt state.
  assign deq  = yumi_i & (count_r != '0);
  assign full = (count_r == cnt_w_lp'(els_p));
  // When full, a same-cycle pop frees the slot the new entry lands in
  // (wr_ptr == rd_ptr); the head is read out before it is overwritten.
  assign enq  = print_stat_v_i & (~full | deq);
  assign drop = print_stat_v_i & ~enq;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      drop_r   <= '0;
    end else begin
      cycle_r <= cycle_r + timestamp_width_p'(1);

      if (enq) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);

      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase

      if (clear_drop_i)
        drop_r <= '0;
      else if (drop && (drop_r != '1))
        drop_r <= drop_r + drop_width_p'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (!reset_i && enq) begin
      tag_mem[wr_ptr_r] <= print_stat_tag_i;
      ts_mem[wr_ptr_r]  <= cycle_r;
    end
  end

  assign v_o          = (count_r != '0);
  assign tag_o        = tag_mem[rd_ptr_r];
  assign timestamp_o  = ts_mem[rd_ptr_r];
  assign count_o      = count_r;
  assign drop_count_o = drop_r;
  assign cycle_o      = cycle_r;

endmodule

// File: tb/tb_bsg_print_stat_event_queue.sv
module tb_bsg_print_stat_event_queue;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        print_stat_v_i = 1'b0;
  logic [31:0] print_stat_tag_i = '0;
  logic        yumi_i = 1'b0;
  logic        clear_drop_i = 1'b0;

  // Instance A: default widths
  logic        a_v;
  logic [31:0] a_tag;
  logic [47:0] a_ts;
  logic [4:0]  a_count;
  logic [15:0] a_drop;
  logic [47:0] a_cycle;

  // Instance B: narrow timestamp and drop counter for wrap/saturation
  logic        b_v;
  logic [31:0] b_tag;
  logic [7:0]  b_ts;
  logic [4:0]  b_count;
  logic [3:0]  b_drop;
  logic [7:0]  b_cycle;

  always #5 clk = ~clk;

  bsg_print_stat_event_queue #(
    .data_width_p(32), .els_p(16), .timestamp_width_p(48), .drop_width_p(16)
  ) dut_a (
    .clk_i(clk), .reset_i(reset_i),
    .print_stat_v_i(print_stat_v_i), .print_stat_tag_i(print_stat_tag_i),
    .v_o(a_v), .tag_o(a_tag), .timestamp_o(a_ts), .yumi_i(yumi_i),
    .count_o(a_count), .drop_count_o(a_drop), .clear_drop_i(clear_drop_i),
    .cycle_o(a_cycle)
  );

  bsg_print_stat_event_queue #(
    .data_width_p(32), .els_p(16), .timestamp_width_p(8), .drop_width_p(4)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_i),
    .print_stat_v_i(print_stat_v_i), .print_stat_tag_i(print_stat_tag_i),
    .v_o(b_v), .tag_o(b_tag), .timestamp_o(b_ts), .yumi_i(yumi_i),
    .count_o(b_count), .drop_count_o(b_drop), .clear_drop_i(clear_drop_i),
    .cycle_o(b_cycle)
  );

  // Reference model: absolute cycle count, unbounded drop tally, FIFO queues.
  // Each instance's view is the same model reduced to its own widths.
  logic [31:0]     qt[$];
  longint unsigned qs[$];
  longint unsigned mcyc = 0;
  int unsigned     drops = 0;
  int unsigned     errors = 0;
  int unsigned     checks = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    logic nonempty;
    nonempty = (qt.size() > 0);
    chk("a_v", 64'(a_v), 64'(nonempty));
    chk("a_count", 64'(a_count), 64'(qt.size()));
    chk("a_drop", 64'(a_drop), 64'((drops > 65535) ? 65535 : drops));
    chk("a_cycle", 64'(a_cycle), mcyc % (64'd1 << 48));
    chk("b_v", 64'(b_v), 64'(nonempty));
    chk("b_count", 64'(b_count), 64'(qt.size()));
    chk("b_drop", 64'(b_drop), 64'((drops > 15) ? 15 : drops));
    chk("b_cycle", 64'(b_cycle), mcyc % 64'd256);
    if (nonempty) begin
      chk("a_tag", 64'(a_tag), 64'(qt[0]));
      chk("a_ts", 64'(a_ts), qs[0] % (64'd1 << 48));
      chk("b_tag", 64'(b_tag), 64'(qt[0]));
      chk("b_ts", 64'(b_ts), qs[0] % 64'd256);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance model, compare.
  task automatic step(input logic v, input logic [31:0] tag, input logic y,
                      input logic clr, input logic rst);
    int   sz;
    logic deq, acc;
    print_stat_v_i   = v;
    print_stat_tag_i = tag;
    yumi_i           = y;
    clear_drop_i     = clr;
    reset_i          = rst;
    sz  = qt.size();
    deq = y && (sz > 0);
    acc = v && ((sz < 16) || deq);
    if (y) begin
      chk("yumi_legal_a", 64'(a_v), 64'd1);
      chk("yumi_legal_b", 64'(b_v), 64'd1);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      qt.delete();
      qs.delete();
      mcyc  = 0;
      drops = 0;
    end else begin
      if (deq) begin
        void'(qt.pop_front());
        void'(qs.pop_front());
      end
      if (acc) begin
        qt.push_back(tag);
        qs.push_back(mcyc);
      end
      if (clr) drops = 0;
      else if (v && !acc) drops++;
      mcyc++;
    end
    print_stat_v_i = 1'b0;
    yumi_i         = 1'b0;
    clear_drop_i   = 1'b0;
    reset_i        = 1'b0;
    check_all();
  endtask

  task automatic drain();
    while (qt.size() > 0) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    // Reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Single event at cycle 5, then pop it
    while (mcyc != 5) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Back-to-back fill with tags 0..15
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);

    // Overflow: 3 drops, then clear wins over a 4th drop
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);

    // Full pass-through, then drain in order (0xAA last)
    step(1'b1, 32'hAA, 1'b1, 1'b0, 1'b0);
    drain();

    // Drop saturation: 20 drops on a full FIFO
    for (int i = 0; i < 16; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic v, y, c;
      v = ($urandom % 4) != 0;
      y = (qt.size() > 0) && (($urandom % 2) == 1);
      c = ($urandom % 16) == 0;
      step(v, $urandom, y, c, 1'b0);
    end
    drain();

    // Narrow timestamp wrap: events at cycle 255 and 0 (mod 256)
    while ((mcyc % 256) != 255) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A_0002, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset mid-stream with a pulse in the reset cycle
    for (int i = 0; i < 5; i++) step(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
